// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed 32x32 multiply / 32/32 divide unit with HI/LO result registers
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             res,
    input  logic             start,
    input  logic             opSel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MULT = 3'd1;
    localparam logic [2:0] S_DIV  = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               op_div_q, op_div_d;
    logic               neg_res_q, neg_res_d;
    logic               sign_a_q, sign_a_d;
    logic               b_zero_q, b_zero_d;
    logic               div_zero_q, div_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_rem;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    always_comb begin
        abs_a     = A[WIDTH-1] ? ('0 - A) : A;
        abs_b     = B[WIDTH-1] ? ('0 - B) : B;
        // acc holds {partial product, remaining multiplier} for MULT and {remainder, dividend/quotient} for DIV
        mult_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_shift[WIDTH-1:0] - opnd_q;
        prod_fix  = neg_res_q ? ('0 - acc_q) : acc_q;
        quot_fix  = neg_res_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
        rem_fix   = sign_a_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_div_d   = op_div_q;
        neg_res_d  = neg_res_q;
        sign_a_d   = sign_a_q;
        b_zero_d   = b_zero_q;
        div_zero_d = div_zero_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = opSel ? S_DIV : S_MULT;
                    cnt_d      = '0;
                    acc_d      = {{WIDTH{1'b0}}, (opSel ? abs_a : abs_b)};
                    opnd_d     = opSel ? abs_b : abs_a;
                    op_div_d   = opSel;
                    neg_res_d  = A[WIDTH-1] ^ B[WIDTH-1];
                    sign_a_d   = A[WIDTH-1];
                    b_zero_d   = (B == '0);
                    div_zero_d = 1'b0;
                end
            end
            S_MULT: begin
                acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (b_zero_q) begin
                    state_d    = S_DONE;
                    div_zero_d = 1'b1;
                end else begin
                    acc_d = div_ge ? {div_rem, acc_q[WIDTH-2:0], 1'b1}
                                   : {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        cnt_d   = '0;
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                hi_d    = op_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
                lo_d    = op_div_q ? quot_fix : prod_fix[WIDTH-1:0];
                state_d = S_DONE;
            end
            S_DONE: begin
                div_zero_d = 1'b0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_div_q   <= 1'b0;
            neg_res_q  <= 1'b0;
            sign_a_q   <= 1'b0;
            b_zero_q   <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_div_q   <= op_div_d;
            neg_res_q  <= neg_res_d;
            sign_a_q   <= sign_a_d;
            b_zero_q   <= b_zero_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy    = (state_q == S_MULT) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign divZero = done && div_zero_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed and random checks of mult_div_unit against a signed-arithmetic scoreboard
module tb_mult_div_unit;

    logic        clock;
    logic        res;
    logic        start;
    logic        opSel;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        divZero;
    logic [31:0] hi;
    logic [31:0] lo;

    mult_div_unit #(.WIDTH(32)) dut (
        .clock   (clock),
        .res     (res),
        .start   (start),
        .opSel   (opSel),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .divZero (divZero),
        .hi      (hi),
        .lo      (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          n_pass;
    int          n_total;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference result built from the language's own signed arithmetic.
    task automatic push_expected(input bit op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        int     ia;
        int     ib;
        ia = int'(a);
        ib = int'(b);
        if (!op) begin
            p    = longint'(ia) * longint'(ib);
            e.hi = p[63:32];
            e.lo = p[31:0];
            e.dz = 1'b0;
            e.lat = 33;
        end else if (b == 32'd0) begin
            e.hi = m_hi;
            e.lo = m_lo;
            e.dz = 1'b1;
            e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.hi = 32'd0;
            e.lo = 32'h8000_0000;
            e.dz = 1'b0;
            e.lat = 33;
        end else begin
            e.lo = 32'(ia / ib);
            e.hi = 32'(ia % ib);
            e.dz = 1'b0;
            e.lat = 33;
        end
        sb.push_back(e);
    endtask

    task automatic run_op(input bit op, input logic [31:0] a, input logic [31:0] b, input int glitch_at);
        exp_t e;
        int   edges;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        prev_hi = m_hi;
        prev_lo = m_lo;
        push_expected(op, a, b);
        opSel = op;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = $urandom;
        opSel = ~op;
        chk("busy_after_accept", 64'(busy), 64'd1);
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            if (edges == glitch_at) begin
                start = 1'b1;
                A     = 32'd99;
                B     = 32'd77;
            end
            tick();
            start = 1'b0;
            edges++;
            if (edges == 5 && busy === 1'b1) begin
                chk("hi_held_midop", 64'(hi), 64'(prev_hi));
                chk("lo_held_midop", 64'(lo), 64'(prev_lo));
            end
        end
        chk("done_seen", 64'(done), 64'd1);
        e = sb.pop_front();
        chk("latency", 64'(edges), 64'(e.lat));
        chk("hi", 64'(hi), 64'(e.hi));
        chk("lo", 64'(lo), 64'(e.lo));
        chk("divZero", 64'(divZero), 64'(e.dz));
        chk("busy_at_done", 64'(busy), 64'd0);
        m_hi = e.hi;
        m_lo = e.lo;
        // A start presented during DONE must be dropped.
        opSel = 1'b0;
        A     = 32'd3;
        B     = 32'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_in_done_ignored", {62'd0, busy, done}, 64'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        m_hi    = 32'd0;
        m_lo    = 32'd0;
        res     = 1'b0;
        start   = 1'b0;
        opSel   = 1'b0;
        A       = 32'd0;
        B       = 32'd0;
        tick();
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_divZero", 64'(divZero), 64'd0);
        chk("reset_hi", 64'(hi), 64'd0);
        chk("reset_lo", 64'(lo), 64'd0);
        res = 1'b1;
        tick();

        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1);
        chk("mult_7_neg3_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_7_neg3_lo", 64'(lo), 64'hFFFF_FFEB);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1);
        chk("mult_min_min_hi", 64'(hi), 64'h4000_0000);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
        chk("div_neg7_2_lo", 64'(lo), 64'hFFFF_FFFD);
        chk("div_neg7_2_hi", 64'(hi), 64'hFFFF_FFFF);
        run_op(1'b0, 32'd6, 32'h2AAA_AAAB, -1);
        chk("preload_hi", 64'(hi), 64'd1);
        chk("preload_lo", 64'(lo), 64'd2);
        run_op(1'b1, 32'd5, 32'd0, -1);
        chk("divzero_hi_kept", 64'(hi), 64'd1);
        chk("divzero_lo_kept", 64'(lo), 64'd2);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(1'b1, 32'd17, 32'hFFFF_FFFB, -1);
        run_op(1'b0, 32'd3, 32'd4, 5);
        chk("ignored_start_lo", 64'(lo), 64'd12);
        chk("ignored_start_hi", 64'(hi), 64'd0);
        for (int i = 0; i < 6; i++) begin
            run_op(1'($urandom_range(0, 1)), $urandom, $urandom, -1);
        end

        opSel = 1'b0;
        A     = 32'd3;
        B     = 32'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        res = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        tick();
        res = 1'b1;
        tick();
        chk("abort_idle_after_release", 64'(busy), 64'd0);
        run_op(1'b1, 32'd100, 32'd7, -1);
        chk("div_100_7_lo", 64'(lo), 64'd14);
        chk("div_100_7_hi", 64'(hi), 64'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand width; only 32 is supported.
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port res, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: a request to begin an operation, sampled only in IDLE.
REQ-005 SHALL have port opSel, input, 1 bit: 0 = MULT (signed), 1 = DIV (signed).
REQ-006 SHALL have port A, input, 32 bits: rs operand (multiplicand or dividend), from register A.
REQ-007 SHALL have port B, input, 32 bits: rt operand (multiplier or divisor), from register B.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: a one-cycle pulse when the result is committed.
REQ-010 SHALL have port divZero, output, 1 bit: a one-cycle pulse, coincident with done, for DIV with B=0.
REQ-011 SHALL have port hi, output, 32 bits: the HI register, i.e. the MULT upper product or the DIV remainder.
REQ-012 SHALL have port lo, output, 32 bits: the LO register, i.e. the MULT lower product or the DIV quotient.

Function
REQ-013 SHALL implement states IDLE, MULT, DIV, FIX and DONE.
REQ-014 SHALL, in IDLE with start=1 at edge N, latch A, B and opSel, the operand signs, and abs(A), abs(B); busy SHALL then be 1 from edge N.
REQ-015 SHALL ignore A, B, opSel and start after latching until the state returns to IDLE.
REQ-016 SHALL, for MULT, take the path IDLE->MULT, run an unsigned shift-add over 32 iterations at edges N+1..N+32, then go to FIX.
REQ-017 SHALL, for DIV with B!=0, take the path IDLE->DIV, run a restoring division over 32 iterations at edges N+1..N+32, then go to FIX.
REQ-018 SHALL, in FIX at edge N+33, sign-correct the result, write hi and lo, and enter DONE.
REQ-019 SHALL apply the MULT sign rule: if the operand signs differ, negate the full 64-bit product (two's complement); hi = [63:32], lo = [31:0].
REQ-020 SHALL apply the DIV quotient sign rule: lo is negated if the signs of A and B differ.
REQ-021 SHALL apply the DIV remainder sign rule: hi takes the sign of A, with magnitude < |B|.
REQ-022 SHALL handle DIV of 0x80000000 by 0xFFFFFFFF as lo=0x80000000, hi=0 (natural wrap); no flag.
REQ-023 SHALL treat abs(0x80000000) as the unsigned value 0x80000000.
REQ-024 SHALL, for DIV with B=0, go IDLE->DONE at edge N+1 without iterating; divZero=1 for that DONE cycle; hi and lo unchanged.
REQ-025 SHALL, in DONE, assert done=1 and busy=0 for exactly one cycle, then go to IDLE on the next edge.
REQ-026 SHALL produce a MULT or nonzero DIV result with done visible in the cycle after edge N+33; total 34 cycles from the start edge.
REQ-027 SHALL hold hi and lo until the next FIX commit or reset; they are readable at any time (MFHI/MFLO).
REQ-028 SHALL ignore start asserted while busy=1 or during DONE; no queueing.
REQ-029 SHALL accept start in IDLE the cycle after DONE (back-to-back).
REQ-030 SHALL use a 6-bit iteration counter, 0..31, cleared on accept; the iteration phase ends after count 31.

Reset
REQ-031 SHALL, when res=0, immediately force state IDLE, busy=0, done=0, divZero=0, hi=0, lo=0, counter=0, and clear all internal operand and accumulator registers.
REQ-032 SHALL, on reset mid-operation, abort the operation with no partial result committed; the first start after res returns to 1 is accepted normally.

Verification
REQ-033 SHALL pass: MULT A=7, B=0xFFFFFFFD -> done 34 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB, divZero=0.
REQ-034 SHALL pass: MULT A=0x80000000, B=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-035 SHALL pass: DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done 34 cycles after start.
REQ-036 SHALL pass: preload hi=1, lo=2; then DIV A=5, B=0 -> done and divZero high in the 2nd cycle; hi=1, lo=2 unchanged.
REQ-037 SHALL pass: start MULT 3x4 and pulse start with new operands at cycle 5 -> result still hi=0, lo=12; the second request is not executed.
REQ-038 SHALL pass: res=0 at cycle 10 of a MULT -> busy, hi and lo are 0 immediately; DIV 100/7 after release -> lo=14, hi=2.
